uart_regs_8n1: RTL and testbench



---
 rtl/uart_regs_8n1_pkg.sv | 23 ++
 rtl/uart_regs_8n1_if.sv | 30 +++
 rtl/uart_regs_8n1_rx_core.sv | 90 +++++++++
 rtl/uart_regs_8n1.sv | 142 ++++++++++++++
 tb/tb_uart_regs_8n1.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_regs_8n1_pkg.sv
// Shared types and constants for the 8N1 UART register block.
// Control bit positions, data width and FSM state encodings.
package uart_pkg;

  localparam int CTRL_SEND_BIT  = 0;
  localparam int CTRL_NEWRX_BIT = 1;
  localparam int DATA_BITS      = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_regs_8n1_if.sv
// Register bus between the core/decoder and the UART block.
// Master drives select/strobe/data, slave returns load data.
interface uart_regs_8n1_if;

  logic        cs_i;
  logic        we_i;
  logic        reg_sel_i;
  logic        addr_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_data_o;

  modport master (
    output cs_i,
    output we_i,
    output reg_sel_i,
    output addr_i,
    output wr_data_i,
    input  rd_data_o
  );

  modport slave (
    input  cs_i,
    input  we_i,
    input  reg_sel_i,
    input  addr_i,
    input  wr_data_i,
    output rd_data_o
  );

endinterface

// File: rtl/uart_regs_8n1_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM.
// Emits a byte with a one-cycle valid pulse on a good stop bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic            meta;
  logic            rx_s;
  rx_state_t       st;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      sh;

  // Bring the asynchronous line into the clock domain (idle high).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx_i;
      rx_s <= meta;
    end
  end

  // Receive FSM; a low start that is gone at mid-bit is a glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st       <= RX_IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) st <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            st  <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            sh  <= {rx_s, sh[7:1]};
            if (idx == LAST_IDX) st <= RX_STOP;
            else idx <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx_s) begin
              rx_byte  <= sh;
              rx_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_regs_8n1.sv
// Memory-mapped 8N1 UART: control/TX/RX registers and TX FSM.
// Reception is delegated to uart_rx_core.
module uart_regs_8n1
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 10_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  uart_regs_8n1_if.slave   bus,
  input  logic             rx_i,
  output logic             tx_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic            send;
  logic            new_rx;
  logic [7:0]      tx_data;
  logic [7:0]      rx_data;
  logic [7:0]      rx_byte;
  logic            rx_valid;
  tx_state_t       tx_st;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_idx;
  logic [7:0]      tx_sh;
  logic            wr;
  logic            wr_ctrl;
  logic            wr_tx;
  logic            send_clr;
  logic [23:0]     unused_wr;

  assign wr       = bus.cs_i & bus.we_i;
  assign wr_ctrl  = wr & ~bus.reg_sel_i;
  assign wr_tx    = wr & bus.reg_sel_i & ~bus.addr_i;
  assign send_clr = (tx_st == TX_STOP) && (tx_cnt == LAST);
  assign unused_wr = bus.wr_data_i[31:8];

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rx_i    (rx_i),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid)
  );

  // Registers: hardware set/clear wins over software in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      send    <= 1'b0;
      new_rx  <= 1'b0;
      tx_data <= '0;
      rx_data <= '0;
    end else begin
      if (send_clr) send <= 1'b0;
      else if (wr_ctrl && tx_st == TX_IDLE)
        send <= bus.wr_data_i[CTRL_SEND_BIT];
      if (rx_valid) new_rx <= 1'b1;
      else if (wr_ctrl) new_rx <= bus.wr_data_i[CTRL_NEWRX_BIT];
      if (wr_tx) tx_data <= bus.wr_data_i[7:0];
      if (rx_valid) rx_data <= rx_byte;
    end
  end

  // Transmit FSM; byte is captured at start so later writes don't disturb it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_o   <= 1'b1;
    end else begin
      case (tx_st)
        TX_IDLE: begin
          tx_o   <= 1'b1;
          tx_cnt <= '0;
          if (send) begin
            tx_sh <= tx_data;
            tx_st <= TX_START;
            tx_o  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            tx_idx <= '0;
            tx_st  <= TX_DATA;
            tx_o   <= tx_sh[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            if (tx_idx == LAST_IDX) begin
              tx_st <= TX_STOP;
              tx_o  <= 1'b1;
            end else begin
              tx_idx <= tx_idx + 1'b1;
              tx_sh  <= tx_sh >> 1;
              tx_o   <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            tx_st  <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  // Zero-latency load data mux.
  always_comb begin
    bus.rd_data_o = '0;
    unique case (1'b1)
      !bus.reg_sel_i:
        bus.rd_data_o[1:0] = {new_rx, send};
      bus.reg_sel_i && !bus.addr_i:
        bus.rd_data_o[7:0] = tx_data;
      bus.reg_sel_i && bus.addr_i:
        bus.rd_data_o[7:0] = rx_data;
      default: bus.rd_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_regs_8n1.sv
// Directed bench for uart_regs_8n1 with CLKS_PER_BIT=16.
// Hand-computed frames for TX, RX, glitch, framing error, overrun.
module tb_uart_regs_8n1;

  logic clk;
  logic rst_n;
  logic rx;
  logic tx;
  int   passed;
  int   total;

  uart_regs_8n1_if bus();

  uart_regs_8n1 #(
    .CLK_FREQ    (160_000),
    .BAUD        (10_000),
    .CLKS_PER_BIT(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus),
    .rx_i  (rx),
    .tx_o  (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic sel, input logic a, input logic [31:0] d);
    @(negedge clk);
    bus.cs_i      = 1'b1;
    bus.we_i      = 1'b1;
    bus.reg_sel_i = sel;
    bus.addr_i    = a;
    bus.wr_data_i = d;
    @(negedge clk);
    bus.cs_i = 1'b0;
    bus.we_i = 1'b0;
  endtask

  task automatic rd(input logic sel, input logic a, output logic [31:0] v);
    bus.reg_sel_i = sel;
    bus.addr_i    = a;
    #1;
    v = bus.rd_data_o;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = f[k];
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic capture_frame(input logic [7:0] b, input bit rewrite);
    logic [9:0] f;
    int bad [10];
    bit ok;
    logic [31:0] v;
    f = {1'b1, b, 1'b0};
    foreach (bad[k]) bad[k] = 0;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (tx === 1'b0) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      $display("FAIL tx_start got no start bit, need one within 50 cycles");
      return;
    end
    passed++;
    bus.reg_sel_i = 1'b0;
    bus.addr_i    = 1'b0;
    for (int i = 0; i < 160; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      if (tx !== f[i/16]) bad[i/16]++;
      if (i == 80) begin
        total++;
        if (bus.rd_data_o !== 32'h1)
          $display("FAIL send_mid got %h need 00000001", bus.rd_data_o);
        else passed++;
      end
      if (rewrite) begin
        if (i == 40) begin
          bus.cs_i = 1'b1;
          bus.we_i = 1'b1;
          bus.reg_sel_i = 1'b0;
          bus.wr_data_i = 32'h1;
        end else if (i == 41) begin
          bus.reg_sel_i = 1'b1;
          bus.addr_i = 1'b0;
          bus.wr_data_i = 32'hFF;
        end else if (i == 42) begin
          bus.cs_i = 1'b0;
          bus.we_i = 1'b0;
          bus.reg_sel_i = 1'b0;
          bus.addr_i = 1'b0;
        end
      end
    end
    for (int k = 0; k < 10; k++) begin
      total++;
      if (bad[k] != 0)
        $display("FAIL tx_bit%0d got %0d wrong samples need 0", k, bad[k]);
      else passed++;
    end
    @(negedge clk);
    #1;
    total++;
    if (tx !== 1'b1) $display("FAIL tx_end got %b need 1", tx);
    else passed++;
    total++;
    if (bus.rd_data_o[0] !== 1'b0)
      $display("FAIL send_clr got %b need 0", bus.rd_data_o[0]);
    else passed++;
    if (rewrite) begin
      ok = 1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        #1;
        if (tx !== 1'b1 || bus.rd_data_o[0] !== 1'b0) ok = 0;
      end
      total++;
      if (!ok) $display("FAIL no_refire got activity need idle");
      else passed++;
      rd(1'b1, 1'b0, v);
      total++;
      if (v !== 32'hFF) $display("FAIL tx_rewrite got %h need 000000ff", v);
      else passed++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rd(1'b0, 1'b0, v);
    total++;
    if (v !== 32'h0) $display("FAIL rst_ctrl got %h need 0", v);
    else passed++;
    rd(1'b1, 1'b0, v);
    total++;
    if (v !== 32'h0) $display("FAIL rst_tx got %h need 0", v);
    else passed++;
    rd(1'b1, 1'b1, v);
    total++;
    if (v !== 32'h0) $display("FAIL rst_rx got %h need 0", v);
    else passed++;
    total++;
    if (tx !== 1'b1) $display("FAIL rst_txo got %b need 1", tx);
    else passed++;
  endtask

  task automatic test_tx();
    logic [31:0] v;
    wr(1'b1, 1'b0, 32'hFFFF_FFA5);
    rd(1'b1, 1'b0, v);
    total++;
    if (v !== 32'hA5) $display("FAIL tx_reg got %h need 000000a5", v);
    else passed++;
    wr(1'b0, 1'b0, 32'h1);
    capture_frame(8'hA5, 1'b0);
  endtask

  task automatic test_rx();
    logic [31:0] v;
    drive_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    rd(1'b0, 1'b0, v);
    total++;
    if (v !== 32'h2) $display("FAIL rx_flag got %h need 00000002", v);
    else passed++;
    rd(1'b1, 1'b1, v);
    total++;
    if (v !== 32'h3C) $display("FAIL rx_data got %h need 0000003c", v);
    else passed++;
    wr(1'b0, 1'b0, 32'h0);
    rd(1'b0, 1'b0, v);
    total++;
    if (v !== 32'h0) $display("FAIL rx_clear got %h need 0", v);
    else passed++;
    wr(1'b1, 1'b1, 32'h77);
    rd(1'b1, 1'b1, v);
    total++;
    if (v !== 32'h3C) $display("FAIL rx_ro got %h need 0000003c", v);
    else passed++;
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    rd(1'b0, 1'b0, v);
    total++;
    if (v !== 32'h0) $display("FAIL glitch_flag got %h need 0", v);
    else passed++;
    rd(1'b1, 1'b1, v);
    total++;
    if (v !== 32'h3C) $display("FAIL glitch_data got %h need 0000003c", v);
    else passed++;
  endtask

  task automatic test_framing();
    logic [31:0] v;
    drive_frame(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    rd(1'b0, 1'b0, v);
    total++;
    if (v !== 32'h0) $display("FAIL frm_flag got %h need 0", v);
    else passed++;
    rd(1'b1, 1'b1, v);
    total++;
    if (v !== 32'h3C) $display("FAIL frm_data got %h need 0000003c", v);
    else passed++;
  endtask

  task automatic test_overrun();
    logic [31:0] v;
    drive_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    rd(1'b1, 1'b1, v);
    total++;
    if (v !== 32'h81) $display("FAIL recover_data got %h need 00000081", v);
    else passed++;
    drive_frame(8'h42, 1'b1);
    repeat (4) @(negedge clk);
    rd(1'b1, 1'b1, v);
    total++;
    if (v !== 32'h42) $display("FAIL ovr_data got %h need 00000042", v);
    else passed++;
    rd(1'b0, 1'b0, v);
    total++;
    if (v !== 32'h2) $display("FAIL ovr_flag got %h need 00000002", v);
    else passed++;
    wr(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    wr(1'b1, 1'b0, 32'h5A);
    wr(1'b0, 1'b0, 32'h1);
    capture_frame(8'h5A, 1'b1);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    rx     = 1'b1;
    bus.cs_i      = 1'b0;
    bus.we_i      = 1'b0;
    bus.reg_sel_i = 1'b0;
    bus.addr_i    = 1'b0;
    bus.wr_data_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_tx();
    test_rx();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
